uart_fifo_core: RTL
===================

Name: uart_fifo_core

Overview:
- Parametrised UART serial engine; successor to the fixed 8N1 receiver/sender/baud-generator set.
- Adds configurable data width, parity, stop bits and baud rate.
- Adds 16x-oversampled RX, TX and RX FIFOs with valid/ready handshakes, and parity/framing/overrun error reporting.
- Sits between the uart_rx/uart_tx pins and the CPU peripheral controller; the controller only pushes and pops words.

Parameters:
- CLK_HZ, 100000000, sysclk frequency in Hz.
- BAUD, 9600, line rate; tick divisor DIV = CLK_HZ/(BAUD*16) rounded down, minimum 1.
- DATA_BITS, 8, payload bits per frame (5..9).
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits transmitted (1 or 2); RX checks only the first stop bit.
- FIFO_DEPTH, 16, entries per FIFO; power of two, 2..256.

Ports:
- sysclk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial input, asynchronous to sysclk.
- uart_tx  out  1  serial output, idles high.
- tx_data  in  DATA_BITS  word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX FIFO can accept a word.
- rx_data  out  DATA_BITS  head of RX FIFO.
- rx_valid  out  1  RX FIFO non-empty.
- rx_ready  in  1  consumer pops the head word.
- tx_busy  out  1  TX FIFO non-empty or frame in progress.
- parity_err  out  1  one-cycle pulse: received parity mismatch.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: RX word lost, FIFO full.

Behaviour:
- Reset (reset=0, asynchronous):
  - uart_tx=1; tx_ready=1; rx_valid=0; rx_data=0; tx_busy=0; all error pulses 0.
  - FIFOs empty, FSMs IDLE, tick counter 0.
- Tick generator:
  - Counter 0..DIV-1; one-cycle tick when the counter equals DIV-1, then wrap to 0.
  - Free-running, shared by RX and TX.
  - One bit period = 16 ticks.
- FIFO transfers:
  - Push on valid&ready; pop on rx_valid&rx_ready.
  - rx_data is first-word-fall-through, registered, valid the cycle rx_valid is high.
  - A full FIFO accepts a push only when a pop occurs in the same cycle; count unchanged, pointers wrap modulo FIFO_DEPTH.
  - Popping an empty FIFO is ignored.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE.
  - IDLE: when the FIFO is non-empty, pop into the shift register on the next tick and enter START.
  - START: drive 0 for 16 ticks.
  - DATA: send LSB first, 16 ticks per bit, DATA_BITS bits.
  - PARITY: odd/even over the payload.
  - STOP: drive 1 for 16*STOP_BITS ticks.
  - STOP -> START directly if the FIFO is non-empty (back-to-back frames, no idle gap).
  - tx_busy falls the cycle STOP completes with the FIFO empty.
- RX path: uart_rx passes a 2-flop synchroniser (input latency 2 cycles).
- RX FSM: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE.
  - IDLE: synchronised falling edge -> START, tick count cleared.
  - START: at tick 8 sample the line. If high, treat as a glitch and return to IDLE with nothing written. Otherwise realign so later samples fall every 16 ticks at mid-bit.
  - DATA: shift in LSB first.
  - PARITY: compare against the computed parity; a mismatch latches a pending parity error.
  - STOP: sample at mid-bit, then resolve in this priority order:
    1. Stop=0: frame_err pulse; word dropped; no parity_err for this frame. Wait for the line high before IDLE (break handling).
    2. Else parity pending: parity_err pulse; word dropped.
    3. Else FIFO full with no pop this cycle: overrun pulse; word dropped, FIFO contents untouched.
    4. Else push the word.
  - Push or pulse occurs one cycle after the stop sample. Return to IDLE immediately, with no wait for the stop-bit end, so the next start edge is detectable.
- Error pulses are mutually exclusive per frame, exactly one cycle wide.
- Reset asserted mid-frame: uart_tx returns to 1 immediately; the partial frame and FIFO contents are discarded.

Decomposition:
- Package uart_pkg: parity-mode constants (PAR_NONE/PAR_ODD/PAR_EVEN), tx_state_t and rx_state_t enums, oversample constant OVS=16, function computing DIV.
- Sub-module uart_sync_fifo (WIDTH, DEPTH): instantiated twice, once each for TX and RX.
- Tick generator, RX FSM and TX FSM stay inline.

Test Plan:
- Loopback (uart_tx to uart_rx), CLK_HZ=1600000, BAUD=100000 (DIV=1, 16 cycles/bit), 8N1: push 0x55, 0xA3, 0x00, 0xFF back-to-back -> rx_data returns the same four words in order. Each frame is 160 cycles on the line, with no gap between frames.
- PARITY=2, DATA_BITS=7: send 0x41 -> line bits after start are 1,0,0,0,0,0,1, parity 0, stop 1. Externally driving parity=1 instead -> parity_err one pulse, rx_valid stays 0.
- Drive a frame with stop bit 0 -> frame_err one pulse, no push. A following valid frame 0x3C received correctly after the line returns high.
- FIFO_DEPTH=4, rx_ready=0: deliver 5 frames -> first 4 stored, overrun pulse on the 5th. Popping then yields the first 4 words in order.
- Glitch: uart_rx low for 4 cycles -> no word, no error pulse, RX back in IDLE. tx_ready=0 after 16 pushes with the line stalled (FIFO_DEPTH=16, tx idle held by continuous sending).
- reset pulsed low mid-TX-frame -> uart_tx=1 within the same cycle, tx_busy=0, tx_ready=1, rx_valid=0. Next push transmits normally.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parametrised UART engine: parity-mode constants,
// TX/RX FSM state encodings, the oversampling ratio and helpers for the baud
// divisor and parity bit.
// -----------------------------------------------------------------------------
package uart_pkg;

  // Ticks per bit period.
  localparam int OVS = 16;

  // Parity modes (value of the PARITY parameter).
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // RX_BREAK holds off new frames until a low stop bit has cleared.
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  // Sysclk cycles per oversample tick, rounded down, never below 1.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * OVS);
    return (d < 1) ? 1 : d;
  endfunction

  // Parity bit to transmit/expect, given the XOR of all payload bits.
  function automatic logic parity_bit(input int mode, input logic payload_xor);
    return (mode == PAR_ODD) ? ~payload_xor : payload_xor;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with first-word-fall-through read data. The head word is
// presented on o_data whenever o_empty is low; o_data reads 0 when empty.
// A full FIFO still accepts a push in a cycle that also pops.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_push       write i_data this cycle (ignored when full without a pop)
//   i_data       write data
//   i_pop        drop the head word (ignored when empty)
//   o_data       head word
//   o_full       DEPTH words stored
//   o_empty      no words stored
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  // Pointers are DEPTH-sized (power of two) so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale entries are unreachable
  // because o_data is masked to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart_fifo_core.sv
// -----------------------------------------------------------------------------
// uart_fifo_core
// Parametrised UART serial engine with 16x-oversampled RX, TX/RX FIFOs and
// parity/framing/overrun error pulses. The controller side only pushes and
// pops words through valid/ready handshakes.
//
// Ports:
//   sysclk      system clock, rising edge
//   reset       asynchronous active-low reset
//   uart_rx     serial input (asynchronous, synchronised internally)
//   uart_tx     serial output, idles high
//   tx_data     word to transmit; tx_valid/tx_ready handshake into TX FIFO
//   rx_data     head of RX FIFO; rx_valid = non-empty, rx_ready pops
//   tx_busy     TX FIFO non-empty or a frame on the line
//   parity_err  one-cycle pulse, received parity mismatch (word dropped)
//   frame_err   one-cycle pulse, stop bit sampled low (word dropped)
//   overrun     one-cycle pulse, RX FIFO full, received word dropped
// -----------------------------------------------------------------------------
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 tx_busy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int          DIV       = calc_div(CLK_HZ, BAUD);
  localparam int          TCW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic [3:0]  OVS_LAST  = 4'(OVS - 1);
  localparam logic [3:0]  OVS_MID   = 4'(OVS / 2 - 1);
  localparam logic [4:0]  TX_OVS_LAST = 5'(OVS - 1);
  localparam logic [4:0]  STOP_LAST = 5'(OVS * STOP_BITS - 1);

  // ---------------------------------------------------------------------------
  // Tick generator: free-running, shared by RX and TX.
  // ---------------------------------------------------------------------------
  logic [TCW-1:0] r_tick_cnt;
  logic           w_tick;

  assign w_tick = (r_tick_cnt == TCW'(DIV - 1));

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)      r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TCW'(1);
  end

  // ---------------------------------------------------------------------------
  // TX FIFO and FSM
  // ---------------------------------------------------------------------------
  tx_state_t            r_tx_state;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic [4:0]           r_tx_ovs;
  logic [3:0]           r_tx_bit;
  logic                 r_uart_tx;
  logic [DATA_BITS-1:0] w_txf_data;
  logic                 w_txf_full;
  logic                 w_txf_empty;
  logic                 w_tx_pop;

  // Pop on the tick that starts a frame: from IDLE, or straight out of STOP
  // so consecutive frames have no idle gap.
  assign w_tx_pop = w_tick && !w_txf_empty &&
                    ((r_tx_state == TX_IDLE) ||
                     (r_tx_state == TX_STOP && r_tx_ovs == STOP_LAST));

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (sysclk),
    .rst_n   (reset),
    .i_push  (tx_valid),
    .i_data  (tx_data),
    .i_pop   (w_tx_pop),
    .o_data  (w_txf_data),
    .o_full  (w_txf_full),
    .o_empty (w_txf_empty)
  );

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_ovs   <= '0;
      r_tx_bit   <= '0;
      r_uart_tx  <= 1'b1;
    end else if (w_tick) begin
      case (r_tx_state)
        TX_IDLE: begin
          if (!w_txf_empty) begin
            r_tx_shift <= w_txf_data;
            r_tx_par   <= parity_bit(PARITY, ^w_txf_data);
            r_tx_ovs   <= '0;
            r_uart_tx  <= 1'b0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_ovs == TX_OVS_LAST) begin
            r_tx_ovs   <= '0;
            r_tx_bit   <= '0;
            r_uart_tx  <= r_tx_shift[0];
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_ovs <= r_tx_ovs + 5'd1;
          end
        end
        TX_DATA: begin
          if (r_tx_ovs == TX_OVS_LAST) begin
            r_tx_ovs <= '0;
            if (r_tx_bit == LAST_BIT) begin
              if (PARITY != PAR_NONE) begin
                r_uart_tx  <= r_tx_par;
                r_tx_state <= TX_PARITY;
              end else begin
                r_uart_tx  <= 1'b1;
                r_tx_state <= TX_STOP;
              end
            end else begin
              r_tx_bit   <= r_tx_bit + 4'd1;
              r_uart_tx  <= r_tx_shift[1];
              r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
            end
          end else begin
            r_tx_ovs <= r_tx_ovs + 5'd1;
          end
        end
        TX_PARITY: begin
          if (r_tx_ovs == TX_OVS_LAST) begin
            r_tx_ovs   <= '0;
            r_uart_tx  <= 1'b1;
            r_tx_state <= TX_STOP;
          end else begin
            r_tx_ovs <= r_tx_ovs + 5'd1;
          end
        end
        TX_STOP: begin
          if (r_tx_ovs == STOP_LAST) begin
            r_tx_ovs <= '0;
            if (!w_txf_empty) begin
              r_tx_shift <= w_txf_data;
              r_tx_par   <= parity_bit(PARITY, ^w_txf_data);
              r_uart_tx  <= 1'b0;
              r_tx_state <= TX_START;
            end else begin
              r_tx_state <= TX_IDLE;
            end
          end else begin
            r_tx_ovs <= r_tx_ovs + 5'd1;
          end
        end
        default: begin
          r_uart_tx  <= 1'b1;
          r_tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  assign uart_tx  = r_uart_tx;
  assign tx_ready = !w_txf_full;
  assign tx_busy  = (r_tx_state != TX_IDLE) || !w_txf_empty;

  // ---------------------------------------------------------------------------
  // RX synchroniser, FSM and FIFO
  // ---------------------------------------------------------------------------
  logic                 r_rx_meta;
  logic                 r_rx_sync;
  logic                 r_rx_prev;
  logic                 w_rx_fall;
  rx_state_t            r_rx_state;
  logic [3:0]           r_rx_ovs;
  logic [3:0]           r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_xor;
  logic                 r_rx_par_pend;
  logic                 r_rx_done;
  logic                 r_rx_stop_ok;
  logic                 w_rx_word_ok;
  logic                 w_rx_pop;
  logic                 w_rx_push;
  logic                 w_rxf_full;
  logic                 w_rxf_empty;

  assign w_rx_fall = r_rx_prev && !r_rx_sync;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // r_rx_done marks the cycle after the stop sample; the word is resolved
  // (pushed or reported) in that cycle while the FSM is already back in IDLE.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_rx_state    <= RX_IDLE;
      r_rx_ovs      <= '0;
      r_rx_bit      <= '0;
      r_rx_shift    <= '0;
      r_rx_xor      <= 1'b0;
      r_rx_par_pend <= 1'b0;
      r_rx_done     <= 1'b0;
      r_rx_stop_ok  <= 1'b0;
    end else begin
      r_rx_done <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) begin
            r_rx_ovs   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (w_tick) begin
            if (r_rx_ovs == OVS_MID) begin
              // Restarting the count at mid start-bit puts every later
              // sample at mid-bit.
              r_rx_ovs <= '0;
              if (r_rx_sync) begin
                r_rx_state <= RX_IDLE;
              end else begin
                r_rx_bit      <= '0;
                r_rx_xor      <= 1'b0;
                r_rx_par_pend <= 1'b0;
                r_rx_state    <= RX_DATA;
              end
            end else begin
              r_rx_ovs <= r_rx_ovs + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (w_tick) begin
            if (r_rx_ovs == OVS_LAST) begin
              r_rx_ovs   <= '0;
              r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
              r_rx_xor   <= r_rx_xor ^ r_rx_sync;
              if (r_rx_bit == LAST_BIT) begin
                r_rx_state <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
              end else begin
                r_rx_bit <= r_rx_bit + 4'd1;
              end
            end else begin
              r_rx_ovs <= r_rx_ovs + 4'd1;
            end
          end
        end
        RX_PARITY: begin
          if (w_tick) begin
            if (r_rx_ovs == OVS_LAST) begin
              r_rx_ovs      <= '0;
              r_rx_par_pend <= (r_rx_sync != parity_bit(PARITY, r_rx_xor));
              r_rx_state    <= RX_STOP;
            end else begin
              r_rx_ovs <= r_rx_ovs + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (w_tick) begin
            if (r_rx_ovs == OVS_LAST) begin
              r_rx_ovs     <= '0;
              r_rx_done    <= 1'b1;
              r_rx_stop_ok <= r_rx_sync;
              r_rx_state   <= r_rx_sync ? RX_IDLE : RX_BREAK;
            end else begin
              r_rx_ovs <= r_rx_ovs + 4'd1;
            end
          end
        end
        RX_BREAK: begin
          if (r_rx_sync) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Resolution priority: framing, then parity, then overrun, else push.
  assign w_rx_word_ok = r_rx_done && r_rx_stop_ok && !r_rx_par_pend;
  assign w_rx_pop     = rx_ready && !w_rxf_empty;
  assign w_rx_push    = w_rx_word_ok && (!w_rxf_full || w_rx_pop);
  assign frame_err    = r_rx_done && !r_rx_stop_ok;
  assign parity_err   = r_rx_done && r_rx_stop_ok && r_rx_par_pend;
  assign overrun      = w_rx_word_ok && w_rxf_full && !w_rx_pop;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (sysclk),
    .rst_n   (reset),
    .i_push  (w_rx_push),
    .i_data  (r_rx_shift),
    .i_pop   (rx_ready),
    .o_data  (rx_data),
    .o_full  (w_rxf_full),
    .o_empty (w_rxf_empty)
  );

  assign rx_valid = !w_rxf_empty;

endmodule
